// File: rtl/crypto_result_buffer.sv
// Buffers the crypto FU's results in order and hands the issue stage a credit (issue_ready_o).
// Define CRYPTO_RESULT_BUFFER_BYPASS_EN to show an incoming result on the outputs in the same cycle.
module crypto_result_buffer #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned DEPTH    = 4,
   parameter type         hartid_t = logic,
   parameter type         id_t     = logic
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            issue_fire_i,
   output logic            issue_ready_o,
   input  logic            in_valid_i,
   input  logic [XLEN-1:0] in_result_i,
   input  hartid_t         in_hartid_i,
   input  id_t             in_id_i,
   input  logic [4:0]      in_rd_i,
   input  logic            in_we_i,
   input  logic            flush_i,
   output logic            result_valid_o,
   input  logic            result_ready_i,
   output logic [XLEN-1:0] result_o,
   output hartid_t         hartid_o,
   output id_t             id_o,
   output logic [4:0]      rd_o,
   output logic            we_o,
   output logic            overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FullCount   = CW'(DEPTH);
   localparam logic [CW:0]   CreditLimit = (CW + 1)'(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] result;
      hartid_t         hartid;
      id_t             id;
      logic [4:0]      rd;
      logic            we;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        mem_d [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          inflight_q, inflight_d;
   logic          overflow_q, overflow_d;

   entry_t in_entry;
   entry_t out_entry;
   logic   empty, full, push, pop, pop_fifo, wr_en, drop, bypass;

   // Credit counts buffered entries plus the one result owed next cycle; registers only.
   assign issue_ready_o = ({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < CreditLimit;
   assign overflow_o    = overflow_q;

   always_comb begin
      in_entry = '{result: in_result_i, hartid: in_hartid_i, id: in_id_i,
                   rd: in_rd_i, we: in_we_i};
      empty    = (count_q == '0);
      full     = (count_q == FullCount);
      push     = in_valid_i && !flush_i;
`ifdef CRYPTO_RESULT_BUFFER_BYPASS_EN
      bypass         = empty && push;
      result_valid_o = (!empty && !flush_i) || bypass;
      out_entry      = bypass ? in_entry : mem_q[rptr_q];
`else
      bypass         = 1'b0;
      result_valid_o = !empty && !flush_i;
      out_entry      = mem_q[rptr_q];
`endif
      pop      = result_valid_o && result_ready_i;
      pop_fifo = pop && !empty;
      // A bypassed result taken immediately never occupies a slot.
      wr_en    = push && !(bypass && result_ready_i) && (!full || pop_fifo);
      drop     = push && full && !pop_fifo;

      if (result_valid_o) begin
         result_o = out_entry.result;
         hartid_o = out_entry.hartid;
         id_o     = out_entry.id;
         rd_o     = out_entry.rd;
         we_o     = out_entry.we;
      end else begin
         result_o = '0;
         hartid_o = '0;
         id_o     = '0;
         rd_o     = '0;
         we_o     = 1'b0;
      end
   end

   always_comb begin
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      inflight_d = inflight_q;
      overflow_d = overflow_q | drop;
      if (flush_i) begin
         wptr_d     = '0;
         rptr_d     = '0;
         count_d    = '0;
         inflight_d = 1'b0;
      end else begin
         inflight_d = issue_fire_i;
         if (wr_en) begin
            mem_d[wptr_q] = in_entry;
            wptr_d        = wptr_q + 1'b1;
         end
         if (pop_fifo) begin
            rptr_d = rptr_q + 1'b1;
         end
         count_d = count_q + CW'(wr_en) - CW'(pop_fifo);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         inflight_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_crypto_result_buffer.sv
// Scoreboard bench for crypto_result_buffer: directed stimulus pushes expected results,
// a negedge monitor pops and compares on every writeback handshake.
module tb_crypto_result_buffer;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned DEPTH = 4;

   typedef logic [3:0] id_t;
   typedef struct packed {
      logic [63:0] result;
      logic        hartid;
      id_t         id;
      logic [4:0]  rd;
      logic        we;
   } exp_t;

   logic            clk_i;
   logic            rst_ni;
   logic            issue_fire_i;
   logic            issue_ready_o;
   logic            in_valid_i;
   logic [XLEN-1:0] in_result_i;
   logic            in_hartid_i;
   id_t             in_id_i;
   logic [4:0]      in_rd_i;
   logic            in_we_i;
   logic            flush_i;
   logic            result_valid_o;
   logic            result_ready_i;
   logic [XLEN-1:0] result_o;
   logic            hartid_o;
   id_t             id_o;
   logic [4:0]      rd_o;
   logic            we_o;
   logic            overflow_o;

   exp_t exp_q[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;

   crypto_result_buffer #(
      .XLEN    (XLEN),
      .DEPTH   (DEPTH),
      .hartid_t(logic),
      .id_t    (id_t)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .issue_fire_i  (issue_fire_i),
      .issue_ready_o (issue_ready_o),
      .in_valid_i    (in_valid_i),
      .in_result_i   (in_result_i),
      .in_hartid_i   (in_hartid_i),
      .in_id_i       (in_id_i),
      .in_rd_i       (in_rd_i),
      .in_we_i       (in_we_i),
      .flush_i       (flush_i),
      .result_valid_o(result_valid_o),
      .result_ready_i(result_ready_i),
      .result_o      (result_o),
      .hartid_o      (hartid_o),
      .id_o          (id_o),
      .rd_o          (rd_o),
      .we_o          (we_o),
      .overflow_o    (overflow_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a handshake seen at the negedge completes on the following posedge.
   always @(negedge clk_i) begin
      if (rst_ni) begin
         if (result_valid_o && result_ready_i) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pop: got id %0h expected no result", id_o);
            end else begin
               mon_e = exp_q.pop_front();
               chk("sb_result", result_o, mon_e.result);
               chk("sb_meta", 64'({hartid_o, id_o, rd_o, we_o}),
                   64'({mon_e.hartid, mon_e.id, mon_e.rd, mon_e.we}));
            end
         end else if (!result_valid_o) begin
            chk("idle_fields_zero", 64'(result_o) | 64'({hartid_o, id_o, rd_o, we_o}), 64'(0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_in();
      issue_fire_i = 1'b0;
      in_valid_i   = 1'b0;
      flush_i      = 1'b0;
      in_result_i  = '0;
      in_hartid_i  = 1'b0;
      in_id_i      = '0;
      in_rd_i      = '0;
      in_we_i      = 1'b0;
   endtask

   task automatic put(input id_t id, input logic [4:0] rd, input logic [63:0] res,
                      input logic we, input logic hart, input bit expect_it);
      in_valid_i  = 1'b1;
      in_id_i     = id;
      in_rd_i     = rd;
      in_result_i = res;
      in_we_i     = we;
      in_hartid_i = hart;
      if (expect_it) exp_q.push_back('{result: res, hartid: hart, id: id, rd: rd, we: we});
   endtask

   initial begin
      rst_ni         = 1'b0;
      result_ready_i = 1'b0;
      idle_in();
      #2;
      chk("rst_valid", 64'(result_valid_o), 64'(0));
      chk("rst_issue_ready", 64'(issue_ready_o), 64'(1));
      chk("rst_overflow", 64'(overflow_o), 64'(0));
      chk("rst_result", result_o, 64'(0));
      chk("rst_meta", 64'({hartid_o, id_o, rd_o, we_o}), 64'(0));
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      cyc(); settle();
      chk("idle_valid", 64'(result_valid_o), 64'(0));
      chk("idle_issue_ready", 64'(issue_ready_o), 64'(1));

      // Single result, consumer always ready
      cyc(); issue_fire_i = 1'b1; result_ready_i = 1'b1;
      cyc(); idle_in(); put(4'd3, 5'd5, 64'hDEAD_BEEF, 1'b1, 1'b0, 1'b1); settle();
`ifdef CRYPTO_RESULT_BUFFER_BYPASS_EN
      chk("single_bypass_valid", 64'(result_valid_o), 64'(1));
      chk("single_bypass_result", result_o, 64'hDEAD_BEEF);
      cyc(); idle_in(); settle();
      chk("single_after_valid", 64'(result_valid_o), 64'(0));
`else
      chk("single_lat0_valid", 64'(result_valid_o), 64'(0));
      cyc(); idle_in(); settle();
      chk("single_lat1_valid", 64'(result_valid_o), 64'(1));
      chk("single_result", result_o, 64'hDEAD_BEEF);
      chk("single_id", 64'(id_o), 64'(3));
      chk("single_rd", 64'(rd_o), 64'(5));
`endif
      cyc(); settle();
      chk("single_drop_valid", 64'(result_valid_o), 64'(0));

      // Fill with consumer stalled: 4 fires, results one cycle behind
      result_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc(); idle_in();
         issue_fire_i = (i < 4);
         if (i > 0) put(id_t'(i - 1), 5'(i + 10), 64'h1000 + 64'(i - 1), i[0], i[1], 1'b1);
         settle();
         chk("fill_issue_ready", 64'(issue_ready_o), 64'(i < 4));
      end

      // Full, forced push with no pop: dropped, sticky overflow
      cyc(); idle_in(); put(4'd9, 5'd1, 64'hBAD, 1'b1, 1'b0, 1'b0); settle();
      chk("full_issue_ready", 64'(issue_ready_o), 64'(0));
      chk("full_valid", 64'(result_valid_o), 64'(1));
      chk("full_head_id", 64'(id_o), 64'(0));
      chk("full_no_overflow_yet", 64'(overflow_o), 64'(0));

      // Full, push together with pop: accepted
      cyc(); idle_in(); put(4'd4, 5'd14, 64'h1004, 1'b0, 1'b1, 1'b1); result_ready_i = 1'b1;
      settle();
      chk("overflow_set", 64'(overflow_o), 64'(1));
      chk("overflow_head_id", 64'(id_o), 64'(0));
      cyc(); idle_in(); settle();
      chk("pushpop_issue_ready", 64'(issue_ready_o), 64'(0));
      chk("pushpop_overflow", 64'(overflow_o), 64'(1));
      chk("pushpop_head_id", 64'(id_o), 64'(1));
      cyc(); settle();
      chk("credit_return", 64'(issue_ready_o), 64'(1));
      repeat (3) cyc();
      settle();
      chk("drain_valid", 64'(result_valid_o), 64'(0));
      chk("drain_sb_empty", 64'(exp_q.size()), 64'(0));

      // Flush with two buffered and one in flight
      result_ready_i = 1'b0;
      cyc(); idle_in(); issue_fire_i = 1'b1;
      cyc(); idle_in(); issue_fire_i = 1'b1; put(4'd5, 5'd2, 64'h55, 1'b1, 1'b0, 1'b1);
      cyc(); idle_in(); issue_fire_i = 1'b1; put(4'd6, 5'd3, 64'h66, 1'b1, 1'b0, 1'b1);
      cyc(); idle_in(); flush_i = 1'b1; put(4'd7, 5'd4, 64'h77, 1'b1, 1'b0, 1'b0);
      exp_q.delete();
      settle();
      chk("flush_cycle_valid", 64'(result_valid_o), 64'(0));
      cyc(); idle_in(); settle();
      chk("post_flush_valid", 64'(result_valid_o), 64'(0));
      chk("post_flush_issue_ready", 64'(issue_ready_o), 64'(1));
      cyc(); settle();
      chk("inflight_ignored_valid", 64'(result_valid_o), 64'(0));

      // Restart after flush: pointers begin afresh
      cyc(); idle_in(); put(4'd8, 5'd8, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 1'b1);
      result_ready_i = 1'b1;
      cyc(); idle_in();
      cyc(); settle();
      chk("restart_sb_empty", 64'(exp_q.size()), 64'(0));
      chk("restart_valid", 64'(result_valid_o), 64'(0));

      // Asynchronous reset mid-operation
      result_ready_i = 1'b0;
      cyc(); idle_in(); put(4'd2, 5'd9, 64'h99, 1'b1, 1'b0, 1'b0);
      cyc(); idle_in(); settle();
      chk("pre_reset_valid", 64'(result_valid_o), 64'(1));
      rst_ni = 1'b0;
      #1;
      chk("midreset_valid", 64'(result_valid_o), 64'(0));
      chk("midreset_overflow", 64'(overflow_o), 64'(0));
      chk("midreset_issue_ready", 64'(issue_ready_o), 64'(1));
      cyc();
      rst_ni = 1'b1;
      cyc(); settle();
      chk("after_reset_valid", 64'(result_valid_o), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
